// File: rtl/seq_limb_mul_pkg.sv
// Shared types and helpers for the limb-serial multiplier.
package seq_limb_mul_pkg;

  localparam int NATIVE_PRODUCT_WIDTH = 32;
  // One spare bit keeps the high-bit slices non-empty at the widest configuration.
  localparam int MAX_W = 513;

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Two's-complement negate when neg is set, result masked to w bits.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input int w,
                                                input logic neg);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return (neg ? (~v + MAX_W'(1)) : v) & mask;
  endfunction

endpackage

// File: rtl/seq_limb_mul_limb_mul.sv
// Single LIMB x LIMB -> 2*LIMB unsigned product, shared by every MUL step.
module limb_mul #(
  parameter int LIMB = 16
) (
  input  logic [LIMB-1:0]   i_a,
  input  logic [LIMB-1:0]   i_b,
  output logic [2*LIMB-1:0] o_p
);

  assign o_p = (2*LIMB)'(i_a) * (2*LIMB)'(i_b);

endmodule

// File: rtl/seq_limb_mul.sv
// Limb-serial wide multiplier: one partial product per cycle, shift-added into a
// Y_WIDTH accumulator, sign applied once at the end.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   MUL   | one limb partial product per cycle, j inner / i outer
//   FIX   | apply sign to accumulator, load y
//   DONE  | y valid, waiting for out_ready
module seq_limb_mul
  import seq_limb_mul_pkg::*;
#(
  parameter int A_WIDTH = 64,
  parameter int B_WIDTH = 64,
  parameter int Y_WIDTH = 128,
  parameter int LIMB    = 16,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               busy
);

  localparam int NA = ceil_div(A_WIDTH, LIMB);
  localparam int NB = ceil_div(B_WIDTH, LIMB);
  localparam int AP = NA * LIMB;
  localparam int BP = NB * LIMB;
  localparam int IW = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(NA - 1);
  localparam logic [JW-1:0] LAST_J = JW'(NB - 1);

  if (2 * LIMB > NATIVE_PRODUCT_WIDTH) begin : g_limb_too_wide
    $error("seq_limb_mul: 2*LIMB exceeds the native product width");
  end

  state_t             r_state, w_next;
  logic [AP-1:0]      r_amag;
  logic [BP-1:0]      r_bmag;
  logic               r_neg;
  logic [IW-1:0]      r_i;
  logic [JW-1:0]      r_j;
  logic [Y_WIDTH-1:0] r_acc, r_y;

  logic               w_a_neg, w_b_neg, w_last, w_unused_hi;
  logic [MAX_W-1:0]   w_amag_full, w_bmag_full, w_fix_full;
  logic [LIMB-1:0]    w_la, w_lb;
  logic [2*LIMB-1:0]  w_pp;
  logic [31:0]        w_shift;
  logic [Y_WIDTH-1:0] w_term;

  assign w_a_neg     = (SIGNED != 0) && a[A_WIDTH-1];
  assign w_b_neg     = (SIGNED != 0) && b[B_WIDTH-1];
  assign w_amag_full = cond_neg(MAX_W'(a), A_WIDTH, w_a_neg);
  assign w_bmag_full = cond_neg(MAX_W'(b), B_WIDTH, w_b_neg);
  assign w_fix_full  = cond_neg(MAX_W'(r_acc), Y_WIDTH, r_neg);
  assign w_unused_hi = ^{w_amag_full[MAX_W-1:AP], w_bmag_full[MAX_W-1:BP],
                         w_fix_full[MAX_W-1:Y_WIDTH]};

  assign w_la    = r_amag[r_i*LIMB +: LIMB];
  assign w_lb    = r_bmag[r_j*LIMB +: LIMB];
  assign w_shift = (32'(r_i) + 32'(r_j)) * 32'(LIMB);
  // Shifts at or past Y_WIDTH give zero but the step still costs its cycle.
  assign w_term  = Y_WIDTH'(w_pp) << w_shift;
  assign w_last  = (r_i == LAST_I) && (r_j == LAST_J);

  limb_mul #(.LIMB(LIMB)) u_limb_mul (
    .i_a (w_la),
    .i_b (w_lb),
    .o_p (w_pp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = MUL;
      MUL:     if (w_last)    w_next = FIX;
      FIX:                    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  assign y = r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_amag <= '0;
      r_bmag <= '0;
      r_neg  <= 1'b0;
      r_i    <= '0;
      r_j    <= '0;
      r_acc  <= '0;
      r_y    <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_amag <= w_amag_full[AP-1:0];
          r_bmag <= w_bmag_full[BP-1:0];
          r_neg  <= w_a_neg ^ w_b_neg;
          r_i    <= '0;
          r_j    <= '0;
          r_acc  <= '0;
        end
        MUL: begin
          r_acc <= r_acc + w_term;
          if (r_j == LAST_J) begin
            r_j <= '0;
            r_i <= (r_i == LAST_I) ? '0 : r_i + IW'(1);
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        FIX:     r_y <= w_fix_full[Y_WIDTH-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_limb_mul.sv
// Self-checking bench: four configurations of seq_limb_mul driven through one
// selectable handshake, expected products queued at acceptance.
module tb_seq_limb_mul;

  logic         clk = 1'b0;
  logic         rst;
  logic         tb_in_valid, tb_out_ready;
  int           tb_sel;
  logic [127:0] tb_a, tb_b;

  logic         ir0, ov0, bz0, ir1, ov1, bz1, ir2, ov2, bz2, ir3, ov3, bz3;
  logic [127:0] y0, y1;
  logic [23:0]  y2;
  logic [63:0]  y3;

  logic         cur_in_ready, cur_out_valid, cur_busy;
  logic [127:0] cur_y;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [127:0] q_y[$];
  int           q_lat[$];

  typedef struct {
    string        name;
    int           sel;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] y;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_limb_mul u_dut (
    .clk(clk), .rst(rst), .in_valid(tb_in_valid && tb_sel == 0), .in_ready(ir0),
    .a(tb_a[63:0]), .b(tb_b[63:0]), .out_valid(ov0), .out_ready(tb_out_ready && tb_sel == 0),
    .y(y0), .busy(bz0));

  seq_limb_mul #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(tb_in_valid && tb_sel == 1), .in_ready(ir1),
    .a(tb_a[63:0]), .b(tb_b[63:0]), .out_valid(ov1), .out_ready(tb_out_ready && tb_sel == 1),
    .y(y1), .busy(bz1));

  seq_limb_mul #(.A_WIDTH(20), .B_WIDTH(12), .Y_WIDTH(24)) u_odd (
    .clk(clk), .rst(rst), .in_valid(tb_in_valid && tb_sel == 2), .in_ready(ir2),
    .a(tb_a[19:0]), .b(tb_b[11:0]), .out_valid(ov2), .out_ready(tb_out_ready && tb_sel == 2),
    .y(y2), .busy(bz2));

  seq_limb_mul #(.Y_WIDTH(64)) u_trn (
    .clk(clk), .rst(rst), .in_valid(tb_in_valid && tb_sel == 3), .in_ready(ir3),
    .a(tb_a[63:0]), .b(tb_b[63:0]), .out_valid(ov3), .out_ready(tb_out_ready && tb_sel == 3),
    .y(y3), .busy(bz3));

  always_comb begin
    cur_in_ready  = ir0;
    cur_out_valid = ov0;
    cur_busy      = bz0;
    cur_y         = y0;
    case (tb_sel)
      1: begin cur_in_ready = ir1; cur_out_valid = ov1; cur_busy = bz1; cur_y = y1; end
      2: begin cur_in_ready = ir2; cur_out_valid = ov2; cur_busy = bz2; cur_y = {104'b0, y2}; end
      3: begin cur_in_ready = ir3; cur_out_valid = ov3; cur_busy = bz3; cur_y = {64'b0, y3}; end
      default: ;
    endcase
  end

  // Behavioural reference product for each configuration.
  function automatic logic [127:0] model(input int sel, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] pa, pb, p;
    case (sel)
      1: begin pa = {{64{a[63]}}, a[63:0]}; pb = {{64{b[63]}}, b[63:0]}; p = pa * pb; end
      2: begin pa = {108'b0, a[19:0]}; pb = {116'b0, b[11:0]}; p = (pa * pb) & 128'hFF_FFFF; end
      3: begin pa = {64'b0, a[63:0]}; pb = {64'b0, b[63:0]}; p = {64'b0, 64'(pa * pb)}; end
      default: begin pa = {64'b0, a[63:0]}; pb = {64'b0, b[63:0]}; p = pa * pb; end
    endcase
    return p;
  endfunction

  // Edges from the acceptance edge (counted as 1) up to the edge raising out_valid.
  function automatic int exp_lat(input int sel);
    return (sel == 2) ? 4 : 18;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic accept(input int sel, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] exp_y);
    int k;
    tb_sel = sel;
    #1;
    for (k = 0; k < 50 && !cur_in_ready; k++) begin
      @(posedge clk); #1;
    end
    check("in_ready_before_accept", {127'b0, cur_in_ready}, 128'd1);
    tb_a = a;
    tb_b = b;
    tb_in_valid = 1'b1;
    q_y.push_back(exp_y);
    q_lat.push_back(exp_lat(sel));
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    tb_a = {$urandom, $urandom, $urandom, $urandom};
    tb_b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic collect(input string name);
    int lat;
    logic [127:0] ey;
    int el;
    lat = 1;
    while (!cur_out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (q_y.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: result with empty scoreboard", name);
    end else begin
      ey = q_y.pop_front();
      el = q_lat.pop_front();
      check({name, "_valid"}, {127'b0, cur_out_valid}, 128'd1);
      check({name, "_y"}, cur_y, ey);
      check({name, "_lat"}, 128'(lat), 128'(el));
    end
  endtask

  task automatic handshake();
    tb_out_ready = 1'b1;
    @(posedge clk); #1;
    tb_out_ready = 1'b0;
    check("hs_out_valid_drop", {127'b0, cur_out_valid}, 128'd0);
    check("hs_in_ready", {127'b0, cur_in_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] ra, rb, held_y;
    rst = 1'b1;
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b0;
    tb_sel = 0;
    tb_a = '0;
    tb_b = '0;

    vecs.push_back('{"u_ones", 0, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF,
                     128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
    vecs.push_back('{"u_zero", 0, 128'h0, 128'hDEAD_BEEF_1234_5678, 128'h0});
    vecs.push_back('{"u_limb", 0, 128'h1_0000, 128'h1_0000, 128'h1_0000_0000});
    vecs.push_back('{"s_min_m1", 1, 128'h8000_0000_0000_0000, 128'hFFFF_FFFF_FFFF_FFFF,
                     128'h0000_0000_0000_0000_8000_0000_0000_0000});
    vecs.push_back('{"s_m3_5", 1, 128'hFFFF_FFFF_FFFF_FFFD, 128'd5,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{"s_m1_m1", 1, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF, 128'd1});
    vecs.push_back('{"s_min_min", 1, 128'h8000_0000_0000_0000, 128'h8000_0000_0000_0000,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000});
    vecs.push_back('{"o_ones", 2, 128'hF_FFFF, 128'hFFF, 128'hEF_F001});
    vecs.push_back('{"o_small", 2, 128'h1_2345, 128'h10, 128'h12_3450});
    vecs.push_back('{"t_2p70", 3, 128'h100_0000_0000, 128'h4000_0000, 128'h0});
    vecs.push_back('{"t_32x32", 3, 128'hFFFF_FFFF, 128'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tb_sel = s;
      #1;
      check("rst_in_ready", {127'b0, cur_in_ready}, 128'd1);
      check("rst_out_valid", {127'b0, cur_out_valid}, 128'd0);
      check("rst_busy", {127'b0, cur_busy}, 128'd0);
      check("rst_y", cur_y, 128'd0);
    end

    foreach (vecs[k]) begin
      accept(vecs[k].sel, vecs[k].a, vecs[k].b, vecs[k].y);
      check({vecs[k].name, "_busy"}, {127'b0, cur_busy}, 128'd1);
      collect(vecs[k].name);
      handshake();
    end

    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 3; r++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        accept(s, ra, rb, model(s, ra, rb));
        collect("rand");
        handshake();
      end
    end

    // Backpressure: new operands presented while the result is held.
    accept(0, 128'd1000, 128'd1000, 128'd1000000);
    collect("bp_first");
    held_y = cur_y;
    tb_a = 128'd2;
    tb_b = 128'd3;
    tb_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_y_stable", cur_y, held_y);
      check("bp_in_ready_low", {127'b0, cur_in_ready}, 128'd0);
      check("bp_out_valid_held", {127'b0, cur_out_valid}, 128'd1);
    end
    handshake();
    accept(0, 128'd2, 128'd3, 128'd6);
    collect("bp_second");
    handshake();

    // Abort mid-MUL, then make sure no stale partial sums leak into the next product.
    accept(0, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0);
    void'(q_y.pop_back());
    void'(q_lat.pop_back());
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {127'b0, cur_in_ready}, 128'd1);
    check("abort_out_valid", {127'b0, cur_out_valid}, 128'd0);
    check("abort_busy", {127'b0, cur_busy}, 128'd0);
    check("abort_y", cur_y, 128'd0);
    accept(0, 128'd3, 128'd7, 128'd21);
    collect("abort_next");
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
